// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one negedge single-port data memory between port 0 (CPU) and port 1 (DMA).
// Latency: gnt one edge after req; a len=L burst issues beats on L+1 cycles, done one edge after the last beat.
// Backpressure: the losing port's request is held pending (never dropped) until the current burst drains.
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the port not served last (port 0 first after reset);
// without it port 0 always wins ties.
module data_memory_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  // port 0 (CPU load/store)
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [LEN_W-1:0]  p0_len,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_wack,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  // port 1 (I/O / DMA)
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [LEN_W-1:0]  p1_len,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_wack,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic              owner_q;          // 0 = port 0, 1 = port 1
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q;           // port granted most recently
`endif

  logic              any_req;
  logic              win_sel;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] own_wdata;

  // Arbitration: pick the port to serve if a burst may start this edge
  always_comb begin
    any_req = p0_req | p1_req;
    win_sel = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req && p1_req) begin
      win_sel = ~last_q;
    end else begin
      win_sel = p1_req & ~p0_req;
    end
`else
    win_sel = p1_req & ~p0_req;
`endif
    win_write = win_sel ? p1_write : p0_write;
    win_addr  = win_sel ? p1_addr  : p0_addr;
    win_len   = win_sel ? p1_len   : p0_len;
    win_wdata = win_sel ? p1_wdata : p0_wdata;
    own_wdata = owner_q ? p1_wdata : p0_wdata;
  end

  // Burst FSM: owns the memory command outputs and the gnt/done pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q     <= win_sel;
            len_q       <= win_len;
            cnt_q       <= '0;
            mem_addr_q  <= win_addr;
            mem_we_q    <= win_write;
            mem_re_q    <= ~win_write;
            mem_wdata_q <= win_wdata;
            gnt_q       <= win_sel ? 2'b10 : 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= win_sel;
`endif
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (cnt_q == len_q) begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            done_q   <= owner_q ? 2'b10 : 2'b01;
            state_q  <= DRAIN;
          end else begin
            cnt_q       <= cnt_q + LEN_W'(1);
            // natural wrap at the top of the address space
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= own_wdata;
          end
        end
        DRAIN: begin
          // one dead cycle so the last read returns before a new owner
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read return: memory data lands one edge after the beat is issued; routed to the owner only
  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q[0] <= mem_re_q & ~owner_q;
      rvalid_q[1] <= mem_re_q &  owner_q;
      rdata0_q    <= (mem_re_q & ~owner_q) ? mem_rdata : '0;
      rdata1_q    <= (mem_re_q &  owner_q) ? mem_rdata : '0;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_done   = done_q[0];
  assign p1_done   = done_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

  // wack is combinational so the requester can present the next word before the next edge
  assign p0_wack   = mem_we_q & ~owner_q;
  assign p1_wack   = mem_we_q &  owner_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: negedge memory model, reference memory image, per-scenario tasks.
module tb_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, wr, gnt, wack, rvalid, done;
  logic [9:0]  ad0, ad1;
  logic [3:0]  ln0, ln1;
  logic [31:0] wdata0, wdata1, rdata0, rdata1;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  logic [31:0] mem_env [1024];   // the physical memory seen by the DUT
  logic [31:0] exp_mem [1024];   // reference image of what memory should hold
  logic [9:0]  addr_trace [$];
  logic [31:0] wd_buf [2][16];
  logic [31:0] rd_buf [2][$];
  int t_req[2], t_gnt[2], t_done[2], t_lrv[2], nwack[2], iso_err[2];
  bit tmo[2];
  int gnt_order [$];

  data_memory_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req(req[0]), .p0_write(wr[0]), .p0_addr(ad0), .p0_len(ln0), .p0_wdata(wdata0),
    .p0_gnt(gnt[0]), .p0_wack(wack[0]), .p0_rvalid(rvalid[0]), .p0_rdata(rdata0), .p0_done(done[0]),
    .p1_req(req[1]), .p1_write(wr[1]), .p1_addr(ad1), .p1_len(ln1), .p1_wdata(wdata1),
    .p1_gnt(gnt[1]), .p1_wack(wack[1]), .p1_rvalid(rvalid[1]), .p1_rdata(rdata1), .p1_done(done[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // memory acts on the falling edge
  always @(negedge clock) begin
    if (mem_we) mem_env[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata = mem_env[mem_addr];
    if (mem_we || mem_re) addr_trace.push_back(mem_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? rdata0 : rdata1;
  endfunction

  task automatic set_wdata(input int p, input logic [31:0] v);
    if (p == 0) wdata0 = v; else wdata1 = v;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // Drives one burst on port p, records timing/data, updates the reference image on a completed write
  task automatic run_burst(input int p, input bit w, input logic [9:0] a, input logic [3:0] l);
    int wi = 0;
    bit granted = 0;
    bit fin = 0;
    rd_buf[p].delete();
    nwack[p] = 0; t_gnt[p] = -1; t_done[p] = -1; t_lrv[p] = -1; tmo[p] = 0;
    wr[p] = w;
    if (p == 0) begin ad0 = a; ln0 = l; end else begin ad1 = a; ln1 = l; end
    set_wdata(p, wd_buf[p][0]);
    req[p] = 1'b1;
    t_req[p] = cyc;
    for (int i = 0; i < 100 && !fin; i++) begin
      step();
      if (!granted && !gnt[p] && ({wack[p], rvalid[p], done[p]} != 3'b000 || rdata_of(p) != 32'h0))
        iso_err[p]++;
      if (gnt[p]) begin granted = 1; t_gnt[p] = cyc; gnt_order.push_back(p); end
      if (wack[p]) begin
        nwack[p]++; wi++;
        if (wi < 16) set_wdata(p, wd_buf[p][wi]);
      end
      if (rvalid[p]) begin rd_buf[p].push_back(rdata_of(p)); t_lrv[p] = cyc; end
      if (done[p]) begin t_done[p] = cyc; fin = 1; end
    end
    req[p] = 1'b0;
    if (!fin) tmo[p] = 1;
    else if (w) for (int k = 0; k <= int'(l); k++) exp_mem[10'(a + 10'(k))] = wd_buf[p][k];
  endtask

  task automatic test_reset();
    logic [113:0] outs;
    outs = {gnt, wack, rvalid, done, rdata0, rdata1, mem_addr, mem_we, mem_re, busy};
    vectors++;
    if (outs !== '0) begin errs++; $display("FAIL reset_initial got %h expected 0", outs); end
    // start a long p1 read then reset in the middle of it
    wr[1] = 1'b0; ad1 = 10'h020; ln1 = 4'd15; req[1] = 1'b1;
    repeat (5) step();
    vectors++;
    if (busy !== 1'b1) begin errs++; $display("FAIL reset_preburst_busy got %b expected 1", busy); end
    req[1] = 1'b0;
    apply_reset(2);
    outs = {gnt, wack, rvalid, done, rdata0, rdata1, mem_addr, mem_we, mem_re, busy};
    vectors++;
    if (outs !== '0 || mem_wdata !== 32'h0) begin
      errs++; $display("FAIL reset_midburst got %h wdata %h expected 0", outs, mem_wdata);
    end
    step();
  endtask

  task automatic test_single();
    wd_buf[0][0] = 32'hDEADBEEF;
    run_burst(0, 1'b1, 10'h010, 4'd0);
    vectors++;
    if (tmo[0] || t_gnt[0] !== t_req[0] + 1 || t_done[0] !== t_gnt[0] + 1 || nwack[0] !== 1) begin
      errs++; $display("FAIL single_write_timing tmo %0d gnt %0d done %0d wack %0d expected gnt %0d done %0d wack 1",
                       tmo[0], t_gnt[0], t_done[0], nwack[0], t_req[0] + 1, t_req[0] + 2);
    end
    step();
    run_burst(0, 1'b0, 10'h010, 4'd0);
    vectors++;
    if (tmo[0] || t_gnt[0] !== t_req[0] + 1 || t_done[0] !== t_gnt[0] + 1 || t_lrv[0] !== t_done[0]) begin
      errs++; $display("FAIL single_read_timing gnt %0d done %0d last_rvalid %0d expected gnt %0d done %0d",
                       t_gnt[0], t_done[0], t_lrv[0], t_req[0] + 1, t_req[0] + 2);
    end
    vectors++;
    if (rd_buf[0].size() != 1 || rd_buf[0][0] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL single_read_data got %0d words first %h expected 1 word deadbeef",
                       rd_buf[0].size(), rd_buf[0].size() > 0 ? rd_buf[0][0] : 32'hx);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [9:0] ea;
    for (int k = 0; k < 4; k++) wd_buf[1][k] = 32'hA000_0000 + 32'(k);
    addr_trace.delete();
    run_burst(1, 1'b1, 10'h3FE, 4'd3);
    vectors++;
    if (tmo[1] || addr_trace.size() != 4 || nwack[1] != 4) begin
      errs++; $display("FAIL wrap_write_beats got %0d addrs %0d wacks expected 4 4", addr_trace.size(), nwack[1]);
    end else begin
      for (int k = 0; k < 4; k++) begin
        ea = 10'h3FE + 10'(k);
        vectors++;
        if (addr_trace[k] !== ea) begin errs++; $display("FAIL wrap_addr[%0d] got %h expected %h", k, addr_trace[k], ea); end
      end
    end
    step();
    run_burst(1, 1'b0, 10'h3FE, 4'd3);
    vectors++;
    if (rd_buf[1].size() != 4 || t_lrv[1] !== t_done[1] || t_done[1] !== t_gnt[1] + 4) begin
      errs++; $display("FAIL wrap_read_timing got %0d words last_rvalid %0d done %0d expected 4 words done %0d",
                       rd_buf[1].size(), t_lrv[1], t_done[1], t_gnt[1] + 4);
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (rd_buf[1][k] !== 32'hA000_0000 + 32'(k)) begin
          errs++; $display("FAIL wrap_rdata[%0d] got %h expected %h", k, rd_buf[1][k], 32'hA000_0000 + 32'(k));
        end
      end
    end
    step();
  endtask

  task automatic test_isolation();
    for (int k = 0; k < 8; k++) wd_buf[0][k] = $urandom;
    iso_err[1] = 0;
    fork
      run_burst(0, 1'b1, 10'h200, 4'd7);
      begin
        repeat (2) step();
        run_burst(1, 1'b0, 10'h010, 4'd1);
      end
    join
    vectors++;
    if (iso_err[1] != 0) begin errs++; $display("FAIL iso_p1_outputs got %0d nonzero samples expected 0", iso_err[1]); end
    vectors++;
    if (tmo[1] || t_gnt[1] !== t_done[0] + 2) begin
      errs++; $display("FAIL iso_p1_gnt got %0d expected %0d", t_gnt[1], t_done[0] + 2);
    end
    vectors++;
    if (rd_buf[1].size() != 2 || rd_buf[1][0] !== exp_mem[10'h010] || rd_buf[1][1] !== exp_mem[10'h011]) begin
      errs++; $display("FAIL iso_p1_rdata got %0d words expected %h %h", rd_buf[1].size(), exp_mem[10'h010], exp_mem[10'h011]);
    end
    step();
  endtask

  task automatic test_abort();
    int nw = 0;
    bit saw_done = 0;
    for (int k = 0; k < 4; k++) begin
      mem_env[10'h100 + 10'(k)] = 32'h5A5A_0000 + 32'(k);
      exp_mem[10'h100 + 10'(k)] = 32'h5A5A_0000 + 32'(k);
      wd_buf[0][k] = $urandom;
    end
    wr[0] = 1'b1; ad0 = 10'h100; ln0 = 4'd3; wdata0 = wd_buf[0][0]; req[0] = 1'b1;
    for (int i = 0; i < 20 && nw < 2; i++) begin
      step();
      if (wack[0]) begin nw++; wdata0 = wd_buf[0][nw]; end
    end
    vectors++;
    if (nw != 2) begin errs++; $display("FAIL abort_start got %0d beats expected 2", nw); end
    reset = 1'b1; req[0] = 1'b0;
    step();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      errs++; $display("FAIL abort_busy got busy %b we %b expected 0 0", busy, mem_we);
    end
    for (int i = 0; i < 6; i++) begin step(); if (done[0]) saw_done = 1; end
    vectors++;
    if (saw_done) begin errs++; $display("FAIL abort_done got 1 expected 0"); end
    exp_mem[10'h100] = wd_buf[0][0];
    exp_mem[10'h101] = wd_buf[0][1];
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (mem_env[10'h100 + 10'(k)] !== exp_mem[10'h100 + 10'(k)]) begin
        errs++; $display("FAIL abort_mem[%0d] got %h expected %h", k, mem_env[10'h100 + 10'(k)], exp_mem[10'h100 + 10'(k)]);
      end
    end
  endtask

  task automatic test_contention();
    int exp_order [4];
    apply_reset(1);
    for (int k = 0; k < 16; k++) begin wd_buf[0][k] = $urandom; wd_buf[1][k] = $urandom; end
    gnt_order.delete();
    fork
      run_burst(0, 1'b1, 10'h300, 4'd2);
      run_burst(1, 1'b1, 10'h308, 4'd1);
    join
    vectors++;
    if (t_gnt[0] !== t_req[0] + 1 || t_gnt[1] !== t_done[0] + 2 || tmo[1]) begin
      errs++; $display("FAIL contend_first got p0 gnt %0d p1 gnt %0d expected %0d %0d",
                       t_gnt[0], t_gnt[1], t_req[0] + 1, t_done[0] + 2);
    end
    step();
    gnt_order.delete();
    fork
      begin run_burst(0, 1'b1, 10'h310, 4'd1); run_burst(0, 1'b1, 10'h312, 4'd0); end
      begin run_burst(1, 1'b1, 10'h318, 4'd2); run_burst(1, 1'b1, 10'h31C, 4'd1); end
    join
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    vectors++;
    if (gnt_order.size() != 4) begin
      errs++; $display("FAIL contend_count got %0d grants expected 4", gnt_order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (gnt_order[k] != exp_order[k]) begin
          errs++; $display("FAIL contend_order[%0d] got p%0d expected p%0d", k, gnt_order[k], exp_order[k]);
        end
      end
    end
    for (int a = 10'h300; a < 10'h320; a++) begin
      vectors++;
      if (mem_env[a] !== exp_mem[a]) begin errs++; $display("FAIL contend_mem[%h] got %h expected %h", a, mem_env[a], exp_mem[a]); end
    end
    step();
  endtask

  task automatic test_random();
    int p;
    bit w;
    logic [9:0] a, ea;
    logic [3:0] l;
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      a = 10'h3F0 + 10'($urandom_range(0, 31));
      l = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) wd_buf[p][k] = $urandom;
      run_burst(p, w, a, l);
      vectors++;
      if (tmo[p] || t_gnt[p] !== t_req[p] + 1 || t_done[p] !== t_gnt[p] + int'(l) + 1) begin
        errs++; $display("FAIL rand%0d_timing p%0d gnt %0d done %0d expected %0d %0d",
                         n, p, t_gnt[p], t_done[p], t_req[p] + 1, t_req[p] + int'(l) + 2);
      end
      vectors++;
      if (nwack[p] != (w ? int'(l) + 1 : 0) || rd_buf[p].size() != (w ? 0 : int'(l) + 1)) begin
        errs++; $display("FAIL rand%0d_beats p%0d wack %0d rvalid %0d len %0d write %0d", n, p, nwack[p], rd_buf[p].size(), l, w);
      end else if (!w) begin
        vectors++;
        if (t_lrv[p] !== t_done[p]) begin errs++; $display("FAIL rand%0d_lastrv got %0d expected %0d", n, t_lrv[p], t_done[p]); end
        for (int k = 0; k <= int'(l); k++) begin
          ea = a + 10'(k);
          vectors++;
          if (rd_buf[p][k] !== exp_mem[ea]) begin
            errs++; $display("FAIL rand%0d_rdata[%0d] got %h expected %h", n, k, rd_buf[p][k], exp_mem[ea]);
          end
        end
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00; wr = 2'b00;
    ad0 = '0; ad1 = '0; ln0 = '0; ln1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) begin mem_env[i] = 32'h0; exp_mem[i] = 32'h0; end
    iso_err[0] = 0; iso_err[1] = 0;
    repeat (2) step();
    reset = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_isolation();
    test_abort();
    test_contention();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
